// File: rtl/drac_pkg.sv
// rtl/drac_pkg.sv - shared types for the exe-stage multiplier and its helpers
package drac_pkg;

    typedef logic [63:0]  bus64_t;
    typedef logic [127:0] bus128_t;

    typedef enum logic [2:0] {
        MUL_OP_MUL    = 3'b000,
        MUL_OP_MULH   = 3'b001,
        MUL_OP_MULHSU = 3'b010,
        MUL_OP_MULHU  = 3'b011
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ACC,
        DONE
    } mul_state_t;

    // MUL treats rs1 as signed too: the low half is the same either way
    function automatic logic op_a_signed(input logic [2:0] func3);
        return (func3 == MUL_OP_MUL) || (func3 == MUL_OP_MULH) || (func3 == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] func3);
        return (func3 == MUL_OP_MUL) || (func3 == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/mul_sign_cond.sv
// rtl/mul_sign_cond.sv - operand magnitude and result-sign conditioning for mul/div
module mul_sign_cond
    import drac_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      func3,
    input  logic            int_32,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b,
    output logic            neg
);

    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            sign_a;
    logic            sign_b;

    // the most negative value negates to itself, which is its exact unsigned magnitude
    always_comb begin
        a_ext = src1;
        b_ext = src2;
        if (int_32) begin
            for (int i = 32; i < XLEN; i++) begin
                a_ext[i] = src1[31];
                b_ext[i] = src2[31];
            end
        end
        sign_a = op_a_signed(func3) & a_ext[XLEN-1];
        sign_b = op_b_signed(func3) & b_ext[XLEN-1];
        abs_a  = sign_a ? -a_ext : a_ext;
        abs_b  = sign_b ? -b_ext : b_ext;
        neg    = sign_a ^ sign_b;
    end

endmodule

// File: rtl/mul_unit_iter.sv
// rtl/mul_unit_iter.sv - iterative RV MUL/MULH/MULHSU/MULHU/MULW unit, one CHUNK of rs2 per cycle
module mul_unit_iter
    import drac_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CHUNK = 32,
    parameter int TAGW  = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            kill_mul_i,
    input  logic            request_i,
    output logic            ready_o,
    input  logic [2:0]      func3_i,
    input  logic            int_32_i,
    input  logic [TAGW-1:0] tag_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [TAGW-1:0] tag_o,
    output logic [XLEN-1:0] result_o
);

    localparam int NCH  = XLEN / CHUNK;
    localparam int NCHW = (CHUNK >= 32) ? 1 : 32 / CHUNK;
    localparam int KW   = $clog2(NCH) + 1;
    localparam logic [KW-1:0] K_LAST   = KW'(NCH - 1);
    localparam logic [KW-1:0] K_LAST_W = KW'(NCHW - 1);

    if ((XLEN % CHUNK) != 0 || (XLEN % 32) != 0) begin : g_bad_params
        $error("mul_unit_iter: XLEN must be a multiple of CHUNK and of 32");
    end

    mul_state_t        state_q;
    logic [2:0]        func3_q;
    logic              int32_q;
    logic [TAGW-1:0]   tag_q;
    logic [2*XLEN-1:0] a_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [KW-1:0]     k_q;

    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              neg;
    logic [2*XLEN-1:0] signed_acc;
    logic [XLEN-1:0]   res;

    // operands are latched raw on accept, conditioning happens from the latched copy in PREP
    mul_sign_cond #(.XLEN(XLEN)) u_sign_cond (
        .func3  (func3_q),
        .int_32 (int32_q),
        .src1   (a_q[XLEN-1:0]),
        .src2   (b_q),
        .abs_a  (abs_a),
        .abs_b  (abs_b),
        .neg    (neg)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            func3_q <= '0;
            int32_q <= 1'b0;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request_i && !kill_mul_i) begin
                        state_q <= PREP;
                        func3_q <= func3_i;
                        int32_q <= int_32_i;
                        tag_q   <= tag_i;
                        a_q     <= {{XLEN{1'b0}}, src1_i};
                        b_q     <= src2_i;
                    end
                end
                PREP: begin
                    state_q <= ACC;
                    a_q     <= {{XLEN{1'b0}}, abs_a};
                    b_q     <= abs_b;
                    neg_q   <= neg;
                    acc_q   <= '0;
                    k_q     <= '0;
                end
                ACC: begin
                    // a_q walks left and b_q right, so slice k lines up without a variable shift
                    acc_q <= acc_q + a_q * {{(2*XLEN-CHUNK){1'b0}}, b_q[CHUNK-1:0]};
                    a_q   <= a_q << CHUNK;
                    b_q   <= b_q >> CHUNK;
                    k_q   <= k_q + 1'b1;
                    if (k_q == (int32_q ? K_LAST_W : K_LAST)) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (kill_mul_i && state_q != IDLE) begin
                state_q <= IDLE;
            end
        end
    end

    always_comb begin
        signed_acc = neg_q ? -acc_q : acc_q;
        res        = '0;
        case (func3_q)
            MUL_OP_MUL: begin
                res = signed_acc[XLEN-1:0];
                if (int32_q) begin
                    for (int i = 32; i < XLEN; i++) begin
                        res[i] = signed_acc[31];
                    end
                end
            end
            MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: res = signed_acc[2*XLEN-1:XLEN];
            default: res = '0;
        endcase
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = ~ready_o;
    assign valid_o  = (state_q == DONE) && !kill_mul_i;
    assign tag_o    = tag_q;
    assign result_o = valid_o ? res : '0;

    a_valid_single: assert property (@(posedge clk_i) disable iff (rst_i) valid_o |=> !valid_o);
    a_busy_ready:   assert property (@(posedge clk_i) busy_o == ~ready_o);

endmodule

// File: tb/tb_mul_unit_iter.sv
// tb/tb_mul_unit_iter.sv - directed self-checking bench for mul_unit_iter
module tb_mul_unit_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        request = 1'b0;
    logic [2:0]  func3 = '0;
    logic        int32 = 1'b0;
    logic [5:0]  tag = '0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [5:0]  tag_out;
    logic [63:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    mul_unit_iter #(.XLEN(64), .CHUNK(32), .TAGW(6)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .kill_mul_i (kill),
        .request_i  (request),
        .ready_o    (ready),
        .func3_i    (func3),
        .int_32_i   (int32),
        .tag_i      (tag),
        .src1_i     (src1),
        .src2_i     (src2),
        .busy_o     (busy),
        .valid_o    (valid),
        .tag_o      (tag_out),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // issue one op, scramble inputs after accept, and wait (bounded) for the result pulse
    task automatic run_op(input logic [2:0] f, input logic w, input logic [5:0] t,
                          input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic [63:0] res, output logic [5:0] tg);
        func3 = f; int32 = w; tag = t; src1 = a; src2 = b; request = 1'b1;
        step();
        request = 1'b0; src1 = ~a; src2 = ~b; tag = ~t; func3 = 3'b111; int32 = ~w;
        lat = -1; res = '0; tg = '0;
        for (int i = 1; i <= 20; i++) begin
            if (valid) begin
                lat = i; res = result; tg = tag_out;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ready, busy, valid} !== 3'b100) begin
            n_bad++; $display("FAIL reset_hs got %b want 100", {ready, busy, valid});
        end
        n_cmp++;
        if (tag_out !== 6'd0 || result !== 64'd0) begin
            n_bad++; $display("FAIL reset_data got tag %h result %h want 0 0", tag_out, result);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int lat; logic [63:0] res; logic [5:0] tg;
        run_op(3'b000, 1'b0, 6'h15, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat, res, tg);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL mul_latency got %0d want 4", lat); end
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mul_result got %h want ffffffffffffffeb", res); end
        n_cmp++;
        if (tg !== 6'h15) begin n_bad++; $display("FAIL mul_tag got %h want 15", tg); end
        step();
        n_cmp++;
        if ({valid, ready} !== 2'b01) begin n_bad++; $display("FAIL mul_after got valid,ready %b want 01", {valid, ready}); end
        run_op(3'b000, 1'b0, 6'h02, 64'h1_0000_0001, 64'h1_0000_0003, lat, res, tg);
        n_cmp++;
        if (res !== 64'h4_0000_0003) begin n_bad++; $display("FAIL mul_two_chunk got %h want 0000000400000003", res); end
        step();
    endtask

    task automatic test_mulw();
        int lat; logic [63:0] res; logic [5:0] tg;
        run_op(3'b000, 1'b1, 6'h21, 64'h0000_0001_8000_0000, 64'd2, lat, res, tg);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL mulw_latency got %0d want 3", lat); end
        n_cmp++;
        if (res !== 64'd0) begin n_bad++; $display("FAIL mulw_min got %h want 0", res); end
        step();
        run_op(3'b000, 1'b1, 6'h22, 64'h1234_5678_FFFF_FFFF, 64'd5, lat, res, tg);
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFB || tg !== 6'h22) begin
            n_bad++; $display("FAIL mulw_sext got %h tag %h want fffffffffffffffb tag 22", res, tg);
        end
        step();
    endtask

    task automatic test_mulh_corner();
        int lat; logic [63:0] res; logic [5:0] tg;
        run_op(3'b001, 1'b0, 6'h03, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat, res, tg);
        n_cmp++;
        if (res !== 64'h4000_0000_0000_0000) begin n_bad++; $display("FAIL mulh_min got %h want 4000000000000000", res); end
        step();
        run_op(3'b000, 1'b0, 6'h04, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat, res, tg);
        n_cmp++;
        if (res !== 64'd0) begin n_bad++; $display("FAIL mul_min got %h want 0", res); end
        step();
    endtask

    task automatic test_mulhu();
        int lat; logic [63:0] res; logic [5:0] tg;
        run_op(3'b011, 1'b0, 6'h05, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, res, tg);
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulhu_max got %h want fffffffffffffffe", res); end
        step();
    endtask

    task automatic test_mulhsu();
        int lat; logic [63:0] res; logic [5:0] tg;
        run_op(3'b010, 1'b0, 6'h06, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, res, tg);
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL mulhsu_neg got %h want ffffffffffffffff", res); end
        step();
        run_op(3'b010, 1'b0, 6'h07, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, lat, res, tg);
        n_cmp++;
        if (res !== 64'd2) begin n_bad++; $display("FAIL mulhsu_pos got %h want 2", res); end
        step();
    endtask

    task automatic test_reserved();
        int lat; logic [63:0] res; logic [5:0] tg;
        run_op(3'b101, 1'b0, 6'h08, 64'd9, 64'd9, lat, res, tg);
        n_cmp++;
        if (lat !== 4 || res !== 64'd0 || tg !== 6'h08) begin
            n_bad++; $display("FAIL reserved got lat %0d result %h tag %h want 4 0 08", lat, res, tg);
        end
        step();
    endtask

    task automatic test_kill();
        logic saw;
        func3 = 3'b000; int32 = 1'b0; tag = 6'h09; src1 = 64'd5; src2 = 64'd6; request = 1'b1;
        step();
        request = 1'b0;
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        n_cmp++;
        if ({ready, busy} !== 2'b10) begin n_bad++; $display("FAIL kill_acc_ready got ready,busy %b want 10", {ready, busy}); end
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (valid) saw = 1'b1;
            step();
        end
        n_cmp++;
        if (saw !== 1'b0) begin n_bad++; $display("FAIL kill_acc_novalid got %b want 0", saw); end
        kill = 1'b1; request = 1'b1;
        step();
        kill = 1'b0; request = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL kill_idle_block got ready %b want 1", ready); end
        request = 1'b1;
        step();
        request = 1'b0;
        step();
        step();
        step();
        kill = 1'b1;
        #1;
        n_cmp++;
        if ({valid, result} !== 65'd0) begin n_bad++; $display("FAIL kill_done got valid %b result %h want 0 0", valid, result); end
        step();
        kill = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL kill_done_ready got %b want 1", ready); end
    endtask

    task automatic test_back_to_back();
        int first, second, rdy;
        logic [63:0] res_a, res_b;
        logic [5:0] tag_a, tag_b;
        func3 = 3'b000; int32 = 1'b0; tag = 6'h01; src1 = 64'd3; src2 = 64'd4; request = 1'b1;
        step();
        func3 = 3'b011; tag = 6'h02; src1 = 64'h8000_0000_0000_0000; src2 = 64'd4;
        first = -1; second = -1; rdy = -1;
        res_a = '0; res_b = '0; tag_a = '0; tag_b = '0;
        for (int i = 1; i <= 15; i++) begin
            if (ready && rdy == -1) rdy = i;
            if (valid) begin
                if (first == -1) begin
                    first = i; res_a = result; tag_a = tag_out;
                end else if (second == -1) begin
                    second = i; res_b = result; tag_b = tag_out;
                end
            end
            step();
        end
        request = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_cmp++;
        if (first !== 4 || rdy !== 5 || second !== 9) begin
            n_bad++; $display("FAIL b2b_timing got valid %0d ready %0d valid2 %0d want 4 5 9", first, rdy, second);
        end
        n_cmp++;
        if (res_a !== 64'd12 || tag_a !== 6'h01) begin n_bad++; $display("FAIL b2b_first got %h tag %h want c tag 01", res_a, tag_a); end
        n_cmp++;
        if (res_b !== 64'd2 || tag_b !== 6'h02) begin n_bad++; $display("FAIL b2b_second got %h tag %h want 2 tag 02", res_b, tag_b); end
    endtask

    task automatic test_rst_mid();
        logic saw;
        func3 = 3'b000; int32 = 1'b0; tag = 6'h2A; src1 = 64'd11; src2 = 64'd13; request = 1'b1;
        step();
        request = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, valid} !== 3'b100 || tag_out !== 6'd0 || result !== 64'd0) begin
            n_bad++; $display("FAIL rst_mid got rbv %b tag %h result %h want 100 0 0", {ready, busy, valid}, tag_out, result);
        end
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (valid) saw = 1'b1;
            step();
        end
        n_cmp++;
        if (saw !== 1'b0) begin n_bad++; $display("FAIL rst_mid_novalid got %b want 0", saw); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulw();
        test_mulh_corner();
        test_mulhu();
        test_mulhsu();
        test_reserved();
        test_kill();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
